// File: rtl/starflux_pkg.sv
// -----------------------------------------------------------------------------
// starflux_pkg
// Shared definitions for the starflux display path:
//   - screen geometry and colour width
//   - named 3-bit RGB colour constants
//   - pixel_addr_t: linear framebuffer address (row * SCREEN_W + column)
//   - sink_state_t: pixel_sink controller states
//   - pixel_addr(): maps (x, y) to a linear address using shifts only
// -----------------------------------------------------------------------------
package starflux_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;
    localparam int PIXELS   = SCREEN_W * SCREEN_H;
    localparam int ADDR_W   = 15;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] RED   = 3'b100;
    localparam logic [COLOUR_W-1:0] GREEN = 3'b010;
    localparam logic [COLOUR_W-1:0] BLUE  = 3'b001;

    typedef logic [ADDR_W-1:0] pixel_addr_t;

    typedef enum logic {
        CLEAR  = 1'b0,
        ACTIVE = 1'b1
    } sink_state_t;

    // y*160 + x as (y<<7) + (y<<5) + x. Both operands are widened to the
    // full address width before shifting so no row bits fall off the top.
    function automatic pixel_addr_t pixel_addr(input logic [7:0] x, input logic [6:0] y);
        pixel_addr_t yw;
        yw = pixel_addr_t'(y);
        return (yw << 7) + (yw << 5) + pixel_addr_t'(x);
    endfunction

endpackage

// File: rtl/sink_ram.sv
// -----------------------------------------------------------------------------
// sink_ram
// Simple dual-port RAM for the shadow framebuffer: one write port, one
// registered read port. A read and a write to the same address in the same
// cycle return the old contents (read-before-write).
// Ports:
//   clk      in   clock
//   we       in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   re       in   read enable; rd_data updates only when high
//   rd_addr  in   read address
//   rd_data  out  registered read data, holds while re is low
// -----------------------------------------------------------------------------
module sink_ram
    import starflux_pkg::*;
#(
    parameter int DEPTH = PIXELS,
    parameter int WIDTH = COLOUR_W
) (
    input  logic             clk,
    input  logic             we,
    input  pixel_addr_t      wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             re,
    input  pixel_addr_t      rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // NOTE: neither the array nor the read register is reset; a reset term
    // would stop the tools mapping this onto block RAM. Contents are
    // initialised by the controller's clear sweep instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pixel_sink.sv
// -----------------------------------------------------------------------------
// pixel_sink
// Passive listener on the {x, y, colour, plot} stream feeding the VGA
// adapter. Mirrors every plot into a 160x120x3 shadow framebuffer that game
// logic can read back, and keeps per-frame statistics. Never stalls the
// scanner.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   plot, x, y, colour   incoming pixel stream
//   rd_req, rd_x, rd_y   read request into the shadow framebuffer
//   rd_valid, rd_colour  read response one cycle later; rd_colour holds
//   busy                 high while the framebuffer is being cleared
//   frame_done           one-cycle pulse after pixel (159,119) is written
//   frame_cnt            completed frames, wrapping
//   lit_cnt              non-black writes in the last completed frame
//   drop_cnt             out-of-range plots since reset, saturating
// -----------------------------------------------------------------------------
module pixel_sink
    import starflux_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    input  logic        rd_req,
    input  logic [7:0]  rd_x,
    input  logic [6:0]  rd_y,
    output logic        rd_valid,
    output logic [2:0]  rd_colour,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [14:0] lit_cnt,
    output logic [7:0]  drop_cnt
);

    sink_state_t   state;
    pixel_addr_t   clr_addr;
    logic [14:0]   lit_run;
    logic          rd_zero;
    logic [2:0]    ram_q;

    logic          in_range;
    logic          rd_in_range;
    logic          plot_active;
    logic          pixel_we;
    logic          last_pixel;
    logic          lit_inc;
    logic          ram_we;
    pixel_addr_t   ram_wr_addr;
    logic [2:0]    ram_wr_data;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        in_range    = 1'b0;
        rd_in_range = 1'b0;
        ram_wr_addr = clr_addr;
        ram_wr_data = BLACK;

        in_range    = (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
        rd_in_range = (rd_x < 8'(SCREEN_W)) && (rd_y < 7'(SCREEN_H));

        if (state == ACTIVE) begin
            ram_wr_addr = pixel_addr(x, y);
            ram_wr_data = colour;
        end
    end

    assign busy        = (state == CLEAR);
    assign plot_active = (state == ACTIVE) && plot;
    assign pixel_we    = plot_active && in_range;
    assign last_pixel  = pixel_we && (x == 8'(SCREEN_W - 1)) && (y == 7'(SCREEN_H - 1));
    assign lit_inc     = pixel_we && (colour != BLACK);
    assign ram_we      = busy || pixel_we;

    // Out-of-range reads never touch the RAM; rd_zero forces the response
    // to black instead. It resets to 1 so rd_colour reads 0 straight out of
    // reset even though the RAM output register itself is not reset.
    assign rd_colour = rd_zero ? BLACK : ram_q;

    sink_ram u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .re      (rd_req && rd_in_range),
        .rd_addr (pixel_addr(rd_x, rd_y)),
        .rd_data (ram_q)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= CLEAR;
            clr_addr   <= '0;
            lit_run    <= '0;
            rd_zero    <= 1'b1;
            rd_valid   <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            lit_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            rd_valid   <= rd_req;
            frame_done <= last_pixel;

            if (rd_req) begin
                rd_zero <= !rd_in_range;
            end

            if (state == CLEAR) begin
                if (clr_addr == pixel_addr_t'(PIXELS - 1)) begin
                    state    <= ACTIVE;
                    clr_addr <= '0;
                end else begin
                    clr_addr <= clr_addr + 1'b1;
                end
            end

            if (plot_active && !in_range && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end

            // The published count includes the final pixel's contribution.
            if (last_pixel) begin
                frame_cnt <= frame_cnt + 1'b1;
                lit_cnt   <= lit_run + 15'(lit_inc);
                lit_run   <= '0;
            end else if (lit_inc) begin
                lit_run <= lit_run + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_sink.sv
// -----------------------------------------------------------------------------
// tb_pixel_sink
// Directed plus randomized stimulus for pixel_sink. A behavioural model holds
// the framebuffer as a plain array and the statistics as integers; every
// cycle's outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_pixel_sink;
    import starflux_pkg::*;

    logic        clk;
    logic        resetn;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        rd_req;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic        rd_valid;
    logic [2:0]  rd_colour;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [14:0] lit_cnt;
    logic [7:0]  drop_cnt;

    pixel_sink dut (
        .clk        (clk),
        .resetn     (resetn),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .rd_req     (rd_req),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_valid   (rd_valid),
        .rd_colour  (rd_colour),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .lit_cnt    (lit_cnt),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [2:0] mdl_mem [0:PIXELS-1];
    int         mdl_run;
    int         mdl_lit;
    int         mdl_frames;
    int         mdl_drops;
    logic [2:0] mdl_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus, entered and left at a falling edge.
    task automatic step(input bit do_plot, input int px, input int py, input int pc,
                        input bit do_rd, input int rx, input int ry);
        bit exp_done;
        exp_done = 1'b0;
        plot   = do_plot;
        x      = px[7:0];
        y      = py[6:0];
        colour = pc[2:0];
        rd_req = do_rd;
        rd_x   = rx[7:0];
        rd_y   = ry[6:0];

        // Read sees the memory before this cycle's write.
        if (do_rd) begin
            if (rx < SCREEN_W && ry < SCREEN_H) mdl_rd = mdl_mem[ry * SCREEN_W + rx];
            else                                mdl_rd = 3'b000;
        end
        if (do_plot) begin
            if (px < SCREEN_W && py < SCREEN_H) begin
                mdl_mem[py * SCREEN_W + px] = pc[2:0];
                if (pc != 0) mdl_run++;
                if (px == SCREEN_W - 1 && py == SCREEN_H - 1) begin
                    exp_done   = 1'b1;
                    mdl_frames = (mdl_frames + 1) % 65536;
                    mdl_lit    = mdl_run;
                    mdl_run    = 0;
                end
            end else if (mdl_drops < 255) begin
                mdl_drops++;
            end
        end

        @(negedge clk);
        plot   = 1'b0;
        rd_req = 1'b0;

        check("frame_done", frame_done, exp_done);
        check("rd_valid",   rd_valid,   do_rd);
        check("rd_colour",  rd_colour,  mdl_rd);
        check("frame_cnt",  frame_cnt,  mdl_frames);
        check("lit_cnt",    lit_cnt,    mdl_lit);
        check("drop_cnt",   drop_cnt,   mdl_drops);
        check("busy",       busy,       0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset held for two cycles, then the clear sweep is timed.
    task automatic do_reset();
        int busy_len;
        @(negedge clk);
        resetn = 1'b0;
        plot   = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy",       busy,       1);
        check("rst_rd_valid",   rd_valid,   0);
        check("rst_rd_colour",  rd_colour,  0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_cnt",  frame_cnt,  0);
        check("rst_lit_cnt",    lit_cnt,    0);
        check("rst_drop_cnt",   drop_cnt,   0);
        mdl_run    = 0;
        mdl_lit    = 0;
        mdl_frames = 0;
        mdl_drops  = 0;
        mdl_rd     = 3'b000;
        resetn = 1'b1;
        busy_len = 0;
        while (busy && busy_len < 25000) begin
            busy_len++;
            @(negedge clk);
        end
        check("busy_len", busy_len, PIXELS);
        for (int i = 0; i < PIXELS; i++) mdl_mem[i] = 3'b000;
    endtask

    task automatic full_frame();
        for (int py = 0; py < SCREEN_H; py++) begin
            for (int px = 0; px < SCREEN_W; px++) begin
                int c;
                c = 0;
                if (px == 7 && py == 2) c = int'(BLUE);
                if (px == 3 && py == 1) c = int'(RED);
                step(1, px, py, c, 0, 0, 0);
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        plot   = 1'b0;
        x      = '0;
        y      = '0;
        colour = '0;
        rd_req = 1'b0;
        rd_x   = '0;
        rd_y   = '0;

        // Reset and clear sweep; cleared memory reads back black.
        do_reset();
        for (int i = 0; i < 32; i++)
            step(0, 0, 0, 0, 1, $urandom_range(0, SCREEN_W - 1), $urandom_range(0, SCREEN_H - 1));
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, SCREEN_W - 1, SCREEN_H - 1);

        // Two full frames with two lit pixels each.
        full_frame();
        check("t4_frame_cnt_1", frame_cnt, 1);
        check("t4_lit_cnt_1",   lit_cnt,   2);
        full_frame();
        check("t4_frame_cnt_2", frame_cnt, 2);
        check("t4_lit_cnt_2",   lit_cnt,   2);
        step(0, 0, 0, 0, 1, 7, 2);
        check("t4_read_blue", rd_colour, BLUE);

        // Plot then read back; response holds afterwards.
        step(1, 5, 1, int'(RED), 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 1);
        check("t2_read_red", rd_colour, RED);
        idle(2);

        // Out-of-range plots, then saturation.
        step(1, SCREEN_W, 0, int'(GREEN), 0, 0, 0);
        step(1, 0, SCREEN_H, int'(GREEN), 0, 0, 0);
        check("t3_drop_2", drop_cnt, 2);
        step(0, 0, 0, 0, 1, SCREEN_W, 0);
        for (int i = 0; i < 300; i++)
            step(1, $urandom_range(SCREEN_W, 255), $urandom_range(0, 127), $urandom_range(0, 7), 0, 0, 0);
        check("t3_drop_sat", drop_cnt, 255);

        // Read-before-write on a collision.
        step(1, 9, 9, int'(RED), 0, 0, 0);
        step(1, 9, 9, int'(GREEN), 1, 9, 9);
        check("t5_old_data", rd_colour, RED);
        step(0, 0, 0, 0, 1, 9, 9);
        check("t5_new_data", rd_colour, GREEN);

        // Randomized traffic, including address collisions.
        for (int i = 0; i < 400; i++) begin
            int px, py, rx, ry;
            px = $urandom_range(0, 175);
            py = $urandom_range(0, 127);
            rx = $urandom_range(0, 175);
            ry = $urandom_range(0, 127);
            if ($urandom_range(0, 3) == 0) begin
                rx = px;
                ry = py;
            end
            step($urandom_range(0, 1), px, py, $urandom_range(0, 7), $urandom_range(0, 1), rx, ry);
        end

        // Reset mid-frame after 50 lit plots.
        for (int i = 0; i < 50; i++)
            step(1, $urandom_range(0, SCREEN_W - 2), $urandom_range(0, SCREEN_H - 1), $urandom_range(1, 7), 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 1, 5, 1);
        check("t6_read_cleared", rd_colour, BLACK);
        step(0, 0, 0, 0, 1, 9, 9);
        step(1, SCREEN_W - 1, SCREEN_H - 1, int'(RED), 0, 0, 0);
        check("t6_frame_after_reset", frame_cnt, 1);
        check("t6_lit_after_reset",   lit_cnt,   1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
